// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RISC-V funct3 encodings for loads and stores
//   - FSM state encoding used by lsu_mem_master
//   - access-size helpers (bytes per access, alignment mask, legality)
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_t;

    // The low two funct3 bits encode log2(size) for every legal load/store;
    // bit 2 only selects zero-extension on loads.
    function automatic logic [3:0] access_bytes(input logic [2:0] f3);
        logic [3:0] n;
        case (f3[1:0])
            2'b00:   n = 4'd1;
            2'b01:   n = 4'd2;
            2'b10:   n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [2:0] f3);
        logic [3:0] m;
        m = access_bytes(f3) - 4'd1;
        return m[2:0];
    endfunction

    // Stores have no unsigned variants; 111 is unused for loads.
    function automatic logic illegal_f3(input logic is_store, input logic [2:0] f3);
        return is_store ? f3[2] : (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Bundle of the LSU request/response handshake and the data-memory port.
//   req_*   : request from the MEM stage (valid/ready, store flag, funct3, addr, wdata)
//   resp_*  : one-cycle response pulse with load data and error flag
//   mem_*   : doubleword data-memory port (index, write data/strobe, read qualifier, read data)
// master modport is the LSU side, slave modport is the pipeline/memory side.
interface lsu_mem_master_if #(
    parameter int ADDR_W = 16,
    parameter int XLEN   = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;

    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] mem_access_addr;
    logic [XLEN-1:0]   mem_write_data;
    logic              mem_write_en;
    logic              mem_read;
    logic [XLEN-1:0]   mem_read_data;

    modport master (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_access_addr, mem_write_data, mem_write_en, mem_read
    );

    modport slave (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  mem_access_addr, mem_write_data, mem_write_en, mem_read
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the LSU (64-bit little-endian words).
//   old_word    : doubleword read from memory
//   wdata       : right-aligned store data
//   offset      : byte offset of the access inside the doubleword
//   funct3      : access size / signedness
//   load_result : addressed field, sign- or zero-extended
//   store_word  : old_word with the addressed bytes replaced by wdata
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] old_word,
    input  logic [XLEN-1:0] wdata,
    input  logic [2:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] load_result,
    output logic [XLEN-1:0] store_word
);

    logic [5:0]      bit_shift;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] size_mask;
    logic [XLEN-1:0] lane_mask;

    assign bit_shift = {offset, 3'b000};

    // Load path: move the addressed field down to bit 0, then extend.
    always_comb begin
        shifted = old_word >> bit_shift;
        case (funct3)
            F3_B:    load_result = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            F3_H:    load_result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_W:    load_result = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            F3_BU:   load_result = {{(XLEN-8){1'b0}},         shifted[7:0]};
            F3_HU:   load_result = {{(XLEN-16){1'b0}},        shifted[15:0]};
            F3_WU:   load_result = {{(XLEN-32){1'b0}},        shifted[31:0]};
            default: load_result = shifted;
        endcase
    end

    // Store path: build a lane mask covering [offset .. offset+size-1] and
    // splice the shifted store data into the old word under that mask.
    always_comb begin
        case (funct3[1:0])
            2'b00:   size_mask = XLEN'(8'hFF);
            2'b01:   size_mask = XLEN'(16'hFFFF);
            2'b10:   size_mask = XLEN'(32'hFFFF_FFFF);
            default: size_mask = '1;
        endcase
        lane_mask  = size_mask << bit_shift;
        store_word = (old_word & ~lane_mask) | ((wdata << bit_shift) & lane_mask);
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit master for the MEM stage's 64-bit data memory.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : lsu_mem_master_if master modport (request, response, memory port)
// Loads read one doubleword and return the extended field. SD writes directly,
// narrower stores do read-modify-write. Misaligned or illegal requests get an
// error response without touching memory. All outputs are registered.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int XLEN   = 64
) (
    input  logic                clk,
    input  logic                rst,
    lsu_mem_master_if.master    bus
);

    state_t            state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [2:0]        offset_q, offset_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] mem_access_addr_q, mem_access_addr_d;
    logic [XLEN-1:0]   mem_write_data_q, mem_write_data_d;
    logic              mem_write_en_q, mem_write_en_d;
    logic              mem_read_q, mem_read_d;

    logic              req_misaligned;
    logic              req_error;
    logic [XLEN-1:0]   load_result;
    logic [XLEN-1:0]   store_word;

    // The RD cycle sees the memory's combinational read data directly, so the
    // old word is consumed in that cycle: extracted for loads, merged for stores.
    lsu_align #(.XLEN(XLEN)) u_align (
        .old_word    (bus.mem_read_data),
        .wdata       (wdata_q),
        .offset      (offset_q),
        .funct3      (funct3_q),
        .load_result (load_result),
        .store_word  (store_word)
    );

    assign req_misaligned = (bus.req_addr[2:0] & align_mask(bus.req_funct3)) != 3'b000;
    assign req_error      = req_misaligned || illegal_f3(bus.req_is_store, bus.req_funct3);

    // Next-state and next-output logic. Strobes and the response default to
    // zero so each is high only in the one state that asserts it.
    always_comb begin
        state_d           = state_q;
        is_store_d        = is_store_q;
        funct3_d          = funct3_q;
        offset_d          = offset_q;
        wdata_d           = wdata_q;
        mem_access_addr_d = mem_access_addr_q;
        mem_write_data_d  = mem_write_data_q;
        resp_valid_d      = 1'b0;
        resp_err_d        = 1'b0;
        resp_rdata_d      = '0;
        mem_write_en_d    = 1'b0;
        mem_read_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    is_store_d = bus.req_is_store;
                    funct3_d   = bus.req_funct3;
                    offset_d   = bus.req_addr[2:0];
                    wdata_d    = bus.req_wdata;
                    if (req_error) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        mem_access_addr_d = {3'b000, bus.req_addr[ADDR_W-1:3]};
                        if (bus.req_is_store && bus.req_funct3 == F3_D) begin
                            // Full doubleword: nothing to preserve, skip the read.
                            state_d          = S_WR;
                            mem_write_en_d   = 1'b1;
                            mem_write_data_d = bus.req_wdata;
                        end else begin
                            state_d    = S_RD;
                            mem_read_d = 1'b1;
                        end
                    end
                end
            end
            S_RD: begin
                if (is_store_q) begin
                    state_d          = S_WR;
                    mem_write_en_d   = 1'b1;
                    mem_write_data_d = store_word;
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_result;
                end
            end
            S_WR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= S_IDLE;
            is_store_q        <= 1'b0;
            funct3_q          <= 3'b000;
            offset_q          <= 3'b000;
            wdata_q           <= '0;
            req_ready_q       <= 1'b1;
            resp_valid_q      <= 1'b0;
            resp_err_q        <= 1'b0;
            resp_rdata_q      <= '0;
            mem_access_addr_q <= '0;
            mem_write_data_q  <= '0;
            mem_write_en_q    <= 1'b0;
            mem_read_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            is_store_q        <= is_store_d;
            funct3_q          <= funct3_d;
            offset_q          <= offset_d;
            wdata_q           <= wdata_d;
            req_ready_q       <= req_ready_d;
            resp_valid_q      <= resp_valid_d;
            resp_err_q        <= resp_err_d;
            resp_rdata_q      <= resp_rdata_d;
            mem_access_addr_q <= mem_access_addr_d;
            mem_write_data_q  <= mem_write_data_d;
            mem_write_en_q    <= mem_write_en_d;
            mem_read_q        <= mem_read_d;
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_err        = resp_err_q;
    assign bus.resp_rdata      = resp_rdata_q;
    assign bus.mem_access_addr = mem_access_addr_q;
    assign bus.mem_write_data  = mem_write_data_q;
    assign bus.mem_write_en    = mem_write_en_q;
    assign bus.mem_read        = mem_read_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: a byte-level reference model predicts
// every cycle of each transaction, a single compare process checks the DUT
// against those predictions, and a few literal values pin the model.
module tb_lsu_mem_master;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;
    int writeCount = 0;

    logic [63:0] lastRdata;
    logic        lastErr;
    logic [63:0] lastWdata;

    lsu_mem_master_if #(.ADDR_W(16), .XLEN(64)) bus ();

    lsu_mem_master #(.ADDR_W(16), .XLEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected DUT outputs for one clock cycle.
    typedef struct {
        bit          ready;
        bit          rv;
        bit          err;
        bit          rd;
        bit          we;
        logic [63:0] rdata;
        logic [15:0] addr;
        logic [63:0] wdata;
    } exp_t;

    exp_t expQ[$];

    logic [63:0] refMem [0:255];
    logic [63:0] mem    [0:255];
    bit          memLoaded;

    function automatic logic [63:0] initWord(input int i);
        case (i)
            1:       return 64'hFEDC_BA98_7654_3210;
            2:       return 64'h0000_0000_0000_0000;
            3:       return 64'hA5A5_A5A5_5A5A_5A5A;
            default: return 64'h1111_1111_1111_1111 * 64'(i);
        endcase
    endfunction

    // Data memory: combinational read, write on the clock edge after the strobe.
    assign bus.mem_read_data = mem[bus.mem_access_addr[7:0]];

    // Memory preload happens on the first edge, then normal write behaviour.
    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= initWord(i);
            memLoaded <= 1'b1;
        end else if (bus.mem_write_en) begin
            mem[bus.mem_access_addr[7:0]] <= bus.mem_write_data;
            writeCount++;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: byte-level view of a RISC-V access on the reference memory.
    task automatic modelAccess(input logic st, input logic [2:0] f3, input logic [15:0] addr,
                               input logic [63:0] wd, output bit err, output logic [63:0] rdata,
                               output bit doRead, output bit doWrite, output logic [63:0] wword);
        int size;
        int off;
        int idx;
        logic [63:0] word;
        size  = 1 << f3[1:0];
        off   = int'(addr[2:0]);
        idx   = int'(addr[15:3]) % 256;
        err   = (st && f3 > 3'd3) || (!st && f3 == 3'd7) || ((off % size) != 0);
        rdata = '0;
        wword = '0;
        doRead = 1'b0;
        doWrite = 1'b0;
        if (!err) begin
            word = refMem[idx];
            if (!st) begin
                doRead = 1'b1;
                for (int b = 0; b < size; b++) rdata[8*b +: 8] = word[8*(off+b) +: 8];
                if (size < 8 && !f3[2] && rdata[8*size-1])
                    for (int b = size; b < 8; b++) rdata[8*b +: 8] = 8'hFF;
            end else begin
                doWrite = 1'b1;
                doRead  = (size != 8);
                wword   = word;
                for (int b = 0; b < size; b++) wword[8*(off+b) +: 8] = wd[8*b +: 8];
                refMem[idx] = wword;
            end
        end
    endtask

    // Issues one request and queues the expected outputs for the idle/accept
    // cycle and every following cycle up to and including the response.
    task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [15:0] addr,
                                 input logic [63:0] wd);
        bit err, doRead, doWrite;
        logic [63:0] rdata, wword;
        exp_t e;
        int lat;
        modelAccess(st, f3, addr, wd, err, rdata, doRead, doWrite, wword);
        e = '{default: 0};
        e.ready = 1'b1;
        expQ.push_back(e);
        lat = 0;
        if (err) begin
            e = '{default: 0};
            e.rv = 1'b1;
            e.err = 1'b1;
            expQ.push_back(e);
            lat++;
        end else begin
            if (doRead) begin
                e = '{default: 0};
                e.rd = 1'b1;
                e.addr = {3'b000, addr[15:3]};
                expQ.push_back(e);
                lat++;
            end
            if (doWrite) begin
                e = '{default: 0};
                e.we = 1'b1;
                e.addr = {3'b000, addr[15:3]};
                e.wdata = wword;
                expQ.push_back(e);
                lat++;
            end
            e = '{default: 0};
            e.rv = 1'b1;
            e.rdata = rdata;
            expQ.push_back(e);
            lat++;
        end
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(posedge clk);
        #2;
        // Scramble the request fields so a DUT that fails to latch them shows it.
        bus.req_valid    = 1'b0;
        bus.req_is_store = ~st;
        bus.req_funct3   = ~f3;
        bus.req_addr     = ~addr;
        bus.req_wdata    = ~wd;
        repeat (lat) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " req_ready"},  64'(bus.req_ready),       64'd1);
        checkOutput({tag, " resp_valid"}, 64'(bus.resp_valid),      64'd0);
        checkOutput({tag, " resp_err"},   64'(bus.resp_err),        64'd0);
        checkOutput({tag, " resp_rdata"}, bus.resp_rdata,           64'd0);
        checkOutput({tag, " mem_we"},     64'(bus.mem_write_en),    64'd0);
        checkOutput({tag, " mem_read"},   64'(bus.mem_read),        64'd0);
        checkOutput({tag, " mem_addr"},   64'(bus.mem_access_addr), 64'd0);
        checkOutput({tag, " mem_wdata"},  bus.mem_write_data,       64'd0);
    endtask

    // Compare process: every falling edge with a queued expectation is checked.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("req_ready",  64'(bus.req_ready),    64'(e.ready));
            checkOutput("resp_valid", 64'(bus.resp_valid),   64'(e.rv));
            checkOutput("mem_read",   64'(bus.mem_read),     64'(e.rd));
            checkOutput("mem_we",     64'(bus.mem_write_en), 64'(e.we));
            if (e.rd || e.we) checkOutput("mem_addr", 64'(bus.mem_access_addr), 64'(e.addr));
            if (e.we) checkOutput("mem_wdata", bus.mem_write_data, e.wdata);
            if (e.rv) begin
                checkOutput("resp_err",   64'(bus.resp_err), 64'(e.err));
                checkOutput("resp_rdata", bus.resp_rdata,    e.rdata);
            end
            if (bus.resp_valid) begin
                lastRdata = bus.resp_rdata;
                lastErr   = bus.resp_err;
            end
            if (bus.mem_write_en) lastWdata = bus.mem_write_data;
        end
    end

    initial begin
        int wBefore;
        for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'b000;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        rst = 1'b1;
        #1;
        checkResetOutputs("reset");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Loads from word 1 = FEDCBA9876543210.
        applyStimulus(1'b0, 3'b000, 16'h000F, 64'h0);
        checkOutput("LB pin", lastRdata, 64'hFFFF_FFFF_FFFF_FFFE);
        applyStimulus(1'b0, 3'b100, 16'h000F, 64'h0);
        checkOutput("LBU pin", lastRdata, 64'h0000_0000_0000_00FE);
        applyStimulus(1'b0, 3'b010, 16'h000C, 64'h0);
        checkOutput("LW pin", lastRdata, 64'hFFFF_FFFF_FEDC_BA98);
        applyStimulus(1'b0, 3'b110, 16'h000C, 64'h0);
        checkOutput("LWU pin", lastRdata, 64'h0000_0000_FEDC_BA98);
        applyStimulus(1'b0, 3'b011, 16'h0008, 64'h0);
        checkOutput("LD pin", lastRdata, 64'hFEDC_BA98_7654_3210);
        applyStimulus(1'b0, 3'b001, 16'h000A, 64'h0);
        checkOutput("LH pin", lastRdata, 64'h0000_0000_0000_7654);
        applyStimulus(1'b0, 3'b101, 16'h000E, 64'h0);
        checkOutput("LHU pin", lastRdata, 64'h0000_0000_0000_FEDC);

        // Sub-word store (read-modify-write) and read-back.
        applyStimulus(1'b1, 3'b001, 16'h000A, 64'h1111_2222_3333_ABCD);
        checkOutput("SH wdata pin", lastWdata, 64'hFEDC_BA98_ABCD_3210);
        applyStimulus(1'b0, 3'b011, 16'h0008, 64'h0);
        checkOutput("LD after SH", lastRdata, 64'hFEDC_BA98_ABCD_3210);

        // Full doubleword store, then a byte store into the same word.
        applyStimulus(1'b1, 3'b011, 16'h0010, 64'h0123_4567_89AB_CDEF);
        checkOutput("SD wdata pin", lastWdata, 64'h0123_4567_89AB_CDEF);
        applyStimulus(1'b1, 3'b000, 16'h0011, 64'hFFFF_FFFF_FFFF_FF5A);
        checkOutput("SB wdata pin", lastWdata, 64'h0123_4567_89AB_5AEF);
        applyStimulus(1'b0, 3'b000, 16'h0011, 64'h0);
        checkOutput("LB after SB", lastRdata, 64'h0000_0000_0000_005A);
        applyStimulus(1'b0, 3'b010, 16'h0014, 64'h0);
        checkOutput("LW word2 hi", lastRdata, 64'h0000_0000_0123_4567);

        // Error responses: misaligned and illegal funct3.
        applyStimulus(1'b0, 3'b001, 16'h0003, 64'h0);
        checkOutput("LH misaligned err", 64'(lastErr), 64'd1);
        applyStimulus(1'b1, 3'b010, 16'h0006, 64'hDEAD_BEEF);
        checkOutput("SW misaligned err", 64'(lastErr), 64'd1);
        applyStimulus(1'b0, 3'b111, 16'h0008, 64'h0);
        checkOutput("load f3=111 err", 64'(lastErr), 64'd1);
        applyStimulus(1'b1, 3'b100, 16'h0008, 64'h0);
        checkOutput("store f3=100 err", 64'(lastErr), 64'd1);
        applyStimulus(1'b1, 3'b011, 16'h0009, 64'h0);
        checkOutput("SD misaligned err", 64'(lastErr), 64'd1);

        // Reset during the read phase of a sub-word store abandons the write.
        wBefore = writeCount;
        begin
            exp_t e;
            e = '{default: 0};
            e.ready = 1'b1;
            expQ.push_back(e);
            e = '{default: 0};
            e.rd = 1'b1;
            e.addr = 16'd3;
            expQ.push_back(e);
        end
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b1;
        bus.req_funct3   = 3'b010;
        bus.req_addr     = 16'h0018;
        bus.req_wdata    = 64'hDEAD_BEEF;
        @(posedge clk);
        #2;
        bus.req_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkResetOutputs("mid-op reset");
        @(posedge clk);
        #1;
        checkOutput("no write during reset", 64'(bus.mem_write_en), 64'd0);
        #1;
        rst = 1'b0;
        checkOutput("write count after reset", 64'(writeCount), 64'(wBefore));
        checkOutput("word3 unchanged", mem[3], 64'hA5A5_A5A5_5A5A_5A5A);
        applyStimulus(1'b0, 3'b011, 16'h0018, 64'h0);
        checkOutput("LD after reset", lastRdata, 64'hA5A5_A5A5_5A5A_5A5A);

        // Final memory image must match the model.
        for (int i = 0; i < 4; i++) checkOutput($sformatf("mem[%0d]", i), mem[i], refMem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
